hazard_ctrl: RTL and testbench

- Hazard/stall controller for the 5-stage MIPS pipeline.
- Drives the Clr_RegDE input of the D→E pipeline register, the stall (hold) for PC and the F→D register, and D-stage forwarding selects.
- Keeps an internal shadow scoreboard of destination register and Tnew for the E, M and W stages.
- Keeps a multiply/divide busy counter so that the stall it asserts matches the bubbles actually inserted into RegDE.

---
 rtl/hazard_ctrl.sv | 77 +++++++
 tb/tb_hazard_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble and D-stage forwarding control for the 5-stage MIPS pipeline,
// using a shadow {wa, tnew} scoreboard for E/M/W and a mult/div busy counter.
module hazard_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_D,
   input  logic [4:0] rt_D,
   input  logic [1:0] Tuse_rs,
   input  logic [1:0] Tuse_rt,
   input  logic [4:0] RFWA_D,
   input  logic [1:0] Tnew_D,
   input  logic       md_start_D,
   input  logic       md_is_div_D,
   input  logic       md_use_D,
   output logic       Stall,
   output logic       Clr_RegDE,
   output logic [1:0] FwdRS_D,
   output logic [1:0] FwdRT_D,
   output logic       md_busy
);
   logic [4:0] e_wa, m_wa, w_wa;
   logic [1:0] e_tn, m_tn;
   logic [3:0] md_cnt;
   logic       stall_rs, stall_rt;

   function automatic logic [1:0] sat_dec(input logic [1:0] x);
      return x == 2'd0 ? 2'd0 : x - 2'd1;
   endfunction

   // W never stalls: its result is already in hand.
   function automatic logic data_stall(input logic [4:0] r, input logic [1:0] tuse,
                                       input logic [4:0] ew, input logic [1:0] et,
                                       input logic [4:0] mw, input logic [1:0] mt);
      return tuse != 2'd3 && r != 5'd0 && ((ew == r && et > tuse) || (mw == r && mt > tuse));
   endfunction

   // A pending E result masks older stages; the stall covers that cycle.
   function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                          input logic [4:0] ew, input logic [1:0] et,
                                          input logic [4:0] mw, input logic [1:0] mt,
                                          input logic [4:0] ww);
      return r == 5'd0 ? 2'd0 :
             ew == r ? (et == 2'd0 ? 2'd1 : 2'd0) :
             (mw == r && mt == 2'd0) ? 2'd2 :
             ww == r ? 2'd3 : 2'd0;
   endfunction

   assign stall_rs  = data_stall(rs_D, Tuse_rs, e_wa, e_tn, m_wa, m_tn);
   assign stall_rt  = data_stall(rt_D, Tuse_rt, e_wa, e_tn, m_wa, m_tn);
   assign md_busy   = md_cnt != 4'd0;
   assign Stall     = stall_rs | stall_rt | (md_use_D & md_busy);
   assign Clr_RegDE = Stall;
   assign FwdRS_D   = fwd_sel(rs_D, e_wa, e_tn, m_wa, m_tn, w_wa);
   assign FwdRT_D   = fwd_sel(rt_D, e_wa, e_tn, m_wa, m_tn, w_wa);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_wa   <= '0;
         e_tn   <= '0;
         m_wa   <= '0;
         m_tn   <= '0;
         w_wa   <= '0;
         md_cnt <= '0;
      end else begin
         e_wa   <= Stall ? 5'd0 : RFWA_D;
         e_tn   <= Stall ? 2'd0 : Tnew_D;
         m_wa   <= e_wa;
         m_tn   <= sat_dec(e_tn);
         w_wa   <= m_wa;
         md_cnt <= (md_start_D && !Stall) ? (md_is_div_D ? 4'(DIV_CYC) : 4'(MULT_CYC)) :
                   md_busy ? md_cnt - 4'd1 : 4'd0;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven vectors for the hazard controller plus hand-written
// mult/div and asynchronous-reset sequences.
module tb_hazard_ctrl;
   typedef struct {
      logic [4:0] rs, rt;
      logic [1:0] tus, tut;
      logic [4:0] wa;
      logic [1:0] tn;
      logic       ms, mdv, mu;
      logic       st;
      logic [1:0] frs, frt;
      logic       bz;
   } vec_t;

   logic       clk = 0, reset = 1;
   logic [4:0] rs_D = 0, rt_D = 0, RFWA_D = 0;
   logic [1:0] Tuse_rs = 3, Tuse_rt = 3, Tnew_D = 0;
   logic       md_start_D = 0, md_is_div_D = 0, md_use_D = 0;
   logic       Stall, Clr_RegDE, md_busy;
   logic [1:0] FwdRS_D, FwdRT_D;
   int         tests = 0, fails = 0;
   vec_t       vq[$];

   hazard_ctrl dut (
      .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D), .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt),
      .RFWA_D(RFWA_D), .Tnew_D(Tnew_D), .md_start_D(md_start_D), .md_is_div_D(md_is_div_D),
      .md_use_D(md_use_D), .Stall(Stall), .Clr_RegDE(Clr_RegDE), .FwdRS_D(FwdRS_D),
      .FwdRT_D(FwdRT_D), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(int rs, int rt, int tus, int tut, int wa, int tn,
                               int ms, int mdv, int mu, int st, int frs, int frt, int bz);
      vec_t x;
      x.rs = 5'(rs); x.rt = 5'(rt); x.tus = 2'(tus); x.tut = 2'(tut);
      x.wa = 5'(wa); x.tn = 2'(tn); x.ms = 1'(ms); x.mdv = 1'(mdv); x.mu = 1'(mu);
      x.st = 1'(st); x.frs = 2'(frs); x.frt = 2'(frt); x.bz = 1'(bz);
      return x;
   endfunction

   task automatic chk(string nm, int got, int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic drive(vec_t x);
      rs_D = x.rs; rt_D = x.rt; Tuse_rs = x.tus; Tuse_rt = x.tut;
      RFWA_D = x.wa; Tnew_D = x.tn; md_start_D = x.ms; md_is_div_D = x.mdv; md_use_D = x.mu;
   endtask

   task automatic check_out(string nm, vec_t x);
      chk({nm, ".Stall"}, Stall, x.st);
      chk({nm, ".Clr_RegDE"}, Clr_RegDE, x.st);
      chk({nm, ".FwdRS_D"}, FwdRS_D, x.frs);
      chk({nm, ".FwdRT_D"}, FwdRT_D, x.frt);
      chk({nm, ".md_busy"}, md_busy, x.bz);
   endtask

   // Called 1 time unit after a rising edge; returns 1 after the next one.
   task automatic apply(string nm, vec_t x);
      drive(x);
      #1;
      check_out(nm, x);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // rs rt tus tut wa tn ms mdv mu | st frs frt bz
      vq.push_back(mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 3, 3, 8, 2, 0, 0, 0, 0, 0, 0, 0));  // lw $8
      vq.push_back(mk(8, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0));  // beq: E tnew 2
      vq.push_back(mk(8, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0));  // beq: M tnew 1
      vq.push_back(mk(8, 0, 0, 3, 0, 0, 0, 0, 0, 0, 3, 0, 0));  // beq issues, from W
      vq.push_back(mk(0, 0, 3, 3, 9, 1, 0, 0, 0, 0, 0, 0, 0));  // addu $9
      vq.push_back(mk(0, 9, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // E tnew 1: no stall, masked
      vq.push_back(mk(0, 9, 3, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0));
      vq.push_back(mk(9, 9, 3, 1, 0, 0, 0, 0, 0, 0, 3, 3, 0));
      vq.push_back(mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 3, 3, 0, 2, 0, 0, 0, 0, 0, 0, 0));  // write to $0
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // read $0
      vq.push_back(mk(0, 0, 3, 3, 10, 1, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(10, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      vq.push_back(mk(10, 0, 0, 3, 0, 0, 0, 0, 0, 0, 2, 0, 0));
      vq.push_back(mk(0, 0, 3, 3, 11, 2, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 11, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // tnew == tuse: no stall
      vq.push_back(mk(0, 11, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // M tnew 1, W empty
      vq.push_back(mk(0, 11, 3, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0));
      vq.push_back(mk(0, 0, 3, 3, 12, 2, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(12, 0, 0, 3, 0, 0, 1, 1, 1, 1, 0, 0, 0)); // stalled div start
      vq.push_back(mk(0, 0, 3, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0));  // counter never loaded

      #1;
      chk("reset.Stall", Stall, 0);
      chk("reset.md_busy", md_busy, 0);
      chk("reset.FwdRS_D", FwdRS_D, 0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 0;

      foreach (vq[i]) apply($sformatf("vec%0d", i), vq[i]);

      // mult then mflo: 5 stalled cycles
      apply("mult", mk(0, 0, 3, 3, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      for (int i = 0; i < 5; i++) apply($sformatf("mflo_wait%0d", i), mk(0, 0, 3, 3, 0, 0, 0, 0, 1, 1, 0, 0, 1));
      apply("mflo_go", mk(0, 0, 3, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0));

      // back-to-back mult then div: div waits for the mult counter
      apply("mult2", mk(0, 0, 3, 3, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      for (int i = 0; i < 5; i++) apply($sformatf("div_wait%0d", i), mk(0, 0, 3, 3, 0, 0, 1, 1, 1, 1, 0, 0, 1));
      apply("div_go", mk(0, 0, 3, 3, 0, 0, 1, 1, 1, 0, 0, 0, 0));
      for (int i = 0; i < 10; i++) apply($sformatf("dmflo_wait%0d", i), mk(0, 0, 3, 3, 0, 0, 0, 0, 1, 1, 0, 0, 1));
      apply("dmflo_go", mk(0, 0, 3, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0));

      // asynchronous reset in the middle of a div stall
      apply("div3", mk(0, 0, 3, 3, 0, 0, 1, 1, 1, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) apply($sformatf("rmflo_wait%0d", i), mk(0, 0, 3, 3, 0, 0, 0, 0, 1, 1, 0, 0, 1));
      #1 reset = 1;
      #1;
      chk("async_rst.Stall", Stall, 0);
      chk("async_rst.Clr_RegDE", Clr_RegDE, 0);
      chk("async_rst.md_busy", md_busy, 0);
      @(posedge clk);
      #1 reset = 0;
      apply("post_rst", mk(0, 0, 3, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
